// File: rtl/gain_offset.sv
// Per-channel black-level subtraction, gain, round-half-up and saturation for a
// Bayer pixel stream. Fixed 3-cycle latency; coefficients are shadowed per frame.
module gain_offset #(
  parameter int GAIN_WIDTH      = 12,
  parameter int GAIN_FRAC_WIDTH = 8,
  parameter int PIXEL_WIDTH     = 10,
  parameter int DATA_WIDTH      = 16,
  parameter int COUNT_WIDTH     = 24,
  parameter int DTYPE_WIDTH     = 4,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 4'h0,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h2,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 4'h3
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     enable,
  input  logic [4*GAIN_WIDTH-1:0]  gains,
  input  logic [4*PIXEL_WIDTH-1:0] blacks,
  input  logic                     init_col_phase,
  input  logic                     init_row_phase,
  input  logic                     dvi,
  input  logic [DTYPE_WIDTH-1:0]   dtypei,
  input  logic [DATA_WIDTH-1:0]    datai,
  output logic                     dvo,
  output logic [DTYPE_WIDTH-1:0]   dtypeo,
  output logic [DATA_WIDTH-1:0]    datao,
  output logic [COUNT_WIDTH-1:0]   clip_count
);
  localparam int PW = PIXEL_WIDTH;
  localparam int GW = GAIN_WIDTH;
  localparam int GF = GAIN_FRAC_WIDTH;
  localparam int RND_SHIFT = (GF > 0) ? GF - 1 : 0;
  localparam logic [PW+GW:0] ROUND = (GF > 0) ? ({{(PW+GW){1'b0}}, 1'b1} << RND_SHIFT) : '0;

  logic [4*GW-1:0] gains_reg;
  logic [4*PW-1:0] blacks_reg;
  logic            enable_reg;
  logic            init_col_reg;
  logic            col_reg, row_reg, first_row_reg;

  logic [GW-1:0] gain_ch [4];
  logic [PW-1:0] black_ch [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      assign gain_ch[gi]  = gains_reg[gi*GW +: GW];
      assign black_ch[gi] = blacks_reg[gi*PW +: PW];
    end
  endgenerate

  logic is_fs, is_rs, is_pix;
  assign is_fs  = dvi && (dtypei == DTYPE_FRAME_START);
  assign is_rs  = dvi && (dtypei == DTYPE_ROW_START);
  assign is_pix = dvi && (dtypei == DTYPE_PIXEL);

  // Stage 1: black subtraction clamped at zero; the gain is carried along so a
  // following FRAME_START cannot swap it underneath an in-flight pixel.
  logic [1:0]  chan;
  logic [PW:0] diff;
  logic [PW-1:0] d_next;
  assign chan   = {row_reg, col_reg};
  assign diff   = {1'b0, datai[PW-1:0]} - {1'b0, black_ch[chan]};
  assign d_next = diff[PW] ? '0 : diff[PW-1:0];

  logic                   dv1_reg, proc1_reg;
  logic [DTYPE_WIDTH-1:0] dtype1_reg;
  logic [DATA_WIDTH-1:0]  data1_reg;
  logic [PW-1:0]          d1_reg;
  logic [GW-1:0]          gain1_reg;

  logic                   dv2_reg, proc2_reg;
  logic [DTYPE_WIDTH-1:0] dtype2_reg;
  logic [DATA_WIDTH-1:0]  data2_reg;
  logic [PW+GW-1:0]       p2_reg;

  logic [PW+GW-1:0] p_next;
  assign p_next = {{GW{1'b0}}, d1_reg} * {{PW{1'b0}}, gain1_reg};

  logic [PW+GW:0]        r_s3;
  logic                  sat_s3, clip_s3, fe_s3;
  logic [PW-1:0]         pix_s3;
  logic [DATA_WIDTH-1:0] data_s3;
  assign r_s3    = {1'b0, p2_reg} + ROUND;
  assign sat_s3  = |r_s3[PW+GW:PW+GF];
  assign pix_s3  = sat_s3 ? '1 : r_s3[PW+GF-1:GF];
  assign data_s3 = proc2_reg ? {{(DATA_WIDTH-PW){1'b0}}, pix_s3} : data2_reg;
  assign clip_s3 = proc2_reg && sat_s3;
  assign fe_s3   = dv2_reg && (dtype2_reg == DTYPE_FRAME_END);

  logic [COUNT_WIDTH-1:0] cnt_reg, cnt_next;
  assign cnt_next = (clip_s3 && !(&cnt_reg)) ? cnt_reg + {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : cnt_reg;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      gains_reg     <= '0;
      blacks_reg    <= '0;
      enable_reg    <= 1'b0;
      init_col_reg  <= 1'b0;
      col_reg       <= 1'b0;
      row_reg       <= 1'b0;
      first_row_reg <= 1'b0;
    end else begin
      if (is_fs) begin
        gains_reg     <= gains;
        blacks_reg    <= blacks;
        enable_reg    <= enable;
        init_col_reg  <= init_col_phase;
        col_reg       <= init_col_phase;
        row_reg       <= init_row_phase;
        first_row_reg <= 1'b1;
      end else if (is_rs) begin
        col_reg <= init_col_reg;
        if (first_row_reg) first_row_reg <= 1'b0;
        else               row_reg       <= ~row_reg;
      end else if (is_pix) begin
        col_reg <= ~col_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      dv1_reg    <= 1'b0;
      proc1_reg  <= 1'b0;
      dtype1_reg <= '0;
      data1_reg  <= '0;
      d1_reg     <= '0;
      gain1_reg  <= '0;
      dv2_reg    <= 1'b0;
      proc2_reg  <= 1'b0;
      dtype2_reg <= '0;
      data2_reg  <= '0;
      p2_reg     <= '0;
      dvo        <= 1'b0;
      dtypeo     <= '0;
      datao      <= '0;
    end else begin
      dv1_reg    <= dvi;
      proc1_reg  <= is_pix && enable_reg;
      dtype1_reg <= dtypei;
      data1_reg  <= datai;
      d1_reg     <= d_next;
      gain1_reg  <= gain_ch[chan];
      dv2_reg    <= dv1_reg;
      proc2_reg  <= proc1_reg;
      dtype2_reg <= dtype1_reg;
      data2_reg  <= data1_reg;
      p2_reg     <= p_next;
      dvo        <= dv2_reg;
      dtypeo     <= dtype2_reg;
      datao      <= data_s3;
    end
  end

  // A FRAME_START entering the pipe clears the counter even over a clip.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_reg    <= '0;
      clip_count <= '0;
    end else begin
      if (fe_s3) clip_count <= cnt_next;
      if (is_fs || fe_s3) cnt_reg <= '0;
      else                cnt_reg <= cnt_next;
    end
  end
endmodule

// File: tb/tb_gain_offset.sv
// Directed bench for gain_offset: scoreboard of expected beats due 3 clocks
// after drive, plus per-frame clip counter checks on two counter widths.
module tb_gain_offset;
  localparam logic [3:0] T_PIX = 4'h0, T_FS = 4'h1, T_FE = 4'h2, T_RS = 4'h3, T_RE = 4'h4;

  logic        clk = 1'b0;
  logic        resetb;
  logic        enable;
  logic [47:0] gains;
  logic [39:0] blacks;
  logic        init_col_phase, init_row_phase;
  logic        dvi;
  logic [3:0]  dtypei;
  logic [15:0] datai;
  logic        dvo, dvo2;
  logic [3:0]  dtypeo, dtypeo2;
  logic [15:0] datao, datao2;
  logic [23:0] clip_count;
  logic [1:0]  clip_count2;

  gain_offset dut (
    .clk(clk), .resetb(resetb), .enable(enable), .gains(gains), .blacks(blacks),
    .init_col_phase(init_col_phase), .init_row_phase(init_row_phase),
    .dvi(dvi), .dtypei(dtypei), .datai(datai),
    .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .clip_count(clip_count)
  );

  gain_offset #(.COUNT_WIDTH(2)) dut2 (
    .clk(clk), .resetb(resetb), .enable(enable), .gains(gains), .blacks(blacks),
    .init_col_phase(init_col_phase), .init_row_phase(init_row_phase),
    .dvi(dvi), .dtypei(dtypei), .datai(datai),
    .dvo(dvo2), .dtypeo(dtypeo2), .datao(datao2), .clip_count(clip_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  t;
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   compared = 0;
  int   failed = 0;
  int   pix_vals [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model(input int pix, input int g, input int b, output bit clip);
    int d, q;
    d = (pix > b) ? pix - b : 0;
    q = (d * g + 128) / 256;
    clip = (q > 1023);
    return clip ? 1023 : q;
  endfunction

  task automatic beat(input logic v, input logic [3:0] t, input logic [15:0] d, input logic [15:0] e);
    exp_t x;
    dvi = v; dtypei = t; datai = d;
    x.v = v; x.t = t; x.d = e; x.due = cyc + 3;
    sb.push_back(x);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      x = sb.pop_front();
      chk("stream", {11'b0, dvo, dtypeo, datao}, {11'b0, x.v, x.t, x.d});
    end
  endtask

  task automatic idle();
    logic [15:0] junk;
    junk = 16'($urandom);
    beat(1'b0, 4'($urandom), junk, junk);
  endtask

  // chg: 0 none, 1 gains -> 2.0 mid-frame, 2 enable -> 0 mid-frame
  task automatic frame(input int rows, input int cols, input bit bub, input int chg);
    logic [47:0] m_g;
    logic [39:0] m_b;
    bit m_en, m_ic, m_ir, cl;
    int ch, pv, e, nclip;
    nclip = 0;
    m_g = gains; m_b = blacks; m_en = enable; m_ic = init_col_phase; m_ir = init_row_phase;
    beat(1'b1, T_FS, 16'h0, 16'h0);
    if (bub) idle();
    for (int r = 0; r < rows; r++) begin
      beat(1'b1, T_RS, 16'(r), 16'(r));
      if (bub) idle();
      for (int c = 0; c < cols; c++) begin
        ch = ((((r + int'(m_ir)) & 1)) << 1) | ((c + int'(m_ic)) & 1);
        pv = pix_vals[r*cols + c];
        cl = 1'b0;
        if (m_en) e = model(pv, int'(m_g[ch*12 +: 12]), int'(m_b[ch*10 +: 10]), cl);
        else      e = pv;
        if (cl) nclip++;
        beat(1'b1, T_PIX, 16'(pv), 16'(e));
        if (bub) idle();
      end
      beat(1'b1, T_RE, 16'hA5A5, 16'hA5A5);
      if (bub) idle();
      if (r == 0 && chg == 1) gains = {4{12'h200}};
      if (r == 0 && chg == 2) enable = 1'b0;
    end
    beat(1'b1, T_FE, 16'h0, 16'h0);
    repeat (4) idle();
    chk("clip_count", {8'b0, clip_count}, 32'(nclip));
    chk("clip_count_w2", {30'b0, clip_count2}, 32'((nclip > 3) ? 3 : nclip));
    $display("frame %0dx%0d en=%0d ic=%0d ir=%0d clips=%0d compared=%0d", rows, cols, m_en, m_ic, m_ir, nclip, compared);
  endtask

  task automatic set_vals(input int n, input int v);
    for (int i = 0; i < n; i++) pix_vals[i] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    resetb = 1'b0; enable = 1'b0; gains = '0; blacks = '0;
    init_col_phase = 1'b0; init_row_phase = 1'b0;
    dvi = 1'b0; dtypei = '0; datai = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dvo", {31'b0, dvo}, 32'd0);
    chk("reset_dtypeo", {28'b0, dtypeo}, 32'd0);
    chk("reset_datao", {16'b0, datao}, 32'd0);
    chk("reset_clip_count", {8'b0, clip_count}, 32'd0);
    resetb = 1'b1;

    // Identity
    enable = 1'b1; gains = {4{12'h100}}; blacks = '0;
    for (int i = 0; i < 16; i++) pix_vals[i] = (i == 15) ? 1023 : i * 68;
    frame(4, 4, 1'b0, 0);

    // Bayer mapping, both column phases
    gains = {12'h180, 12'h080, 12'h200, 12'h100};
    set_vals(16, 100);
    frame(4, 4, 1'b0, 0);
    init_col_phase = 1'b1;
    frame(4, 4, 1'b0, 0);
    init_col_phase = 1'b0;

    // Rounding
    gains = {4{12'h080}};
    pix_vals[0] = 3; pix_vals[1] = 3; pix_vals[2] = 5; pix_vals[3] = 1;
    frame(1, 4, 1'b0, 0);

    // Black level
    gains = {4{12'h100}}; blacks = {4{10'd64}};
    pix_vals[0] = 50; pix_vals[1] = 164; pix_vals[2] = 64; pix_vals[3] = 1023;
    frame(1, 4, 1'b0, 0);

    // Saturation
    blacks = '0; gains = {4{12'h200}};
    pix_vals[0] = 511; pix_vals[1] = 512; pix_vals[2] = 1000; pix_vals[3] = 0;
    frame(1, 4, 1'b0, 0);
    set_vals(8, 1023); pix_vals[2] = 100; pix_vals[6] = 0;
    frame(2, 4, 1'b0, 0);

    // Frame-atomic updates
    gains = {4{12'h100}};
    for (int i = 0; i < 8; i++) pix_vals[i] = i * 50;
    frame(2, 4, 1'b0, 1);
    frame(2, 4, 1'b0, 0);
    frame(2, 4, 1'b0, 2);
    frame(2, 4, 1'b0, 0);

    // Bubbles
    enable = 1'b1; gains = {12'h180, 12'h080, 12'h200, 12'h100};
    set_vals(8, 100);
    frame(2, 4, 1'b1, 0);

    // Reset mid-frame
    gains = {4{12'h100}};
    beat(1'b1, T_FS, 16'h0, 16'h0);
    beat(1'b1, T_RS, 16'h0, 16'h0);
    beat(1'b1, T_PIX, 16'd7, 16'd7);
    idle();
    beat(1'b1, T_PIX, 16'd9, 16'd9);
    resetb = 1'b0; dvi = 1'b0;
    sb.delete();
    #1;
    chk("midreset_dvo", {31'b0, dvo}, 32'd0);
    chk("midreset_datao", {16'b0, datao}, 32'd0);
    chk("midreset_dtypeo", {28'b0, dtypeo}, 32'd0);
    chk("midreset_clip_count", {8'b0, clip_count}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetb = 1'b1;
    $display("reset mid-frame flushed");

    // Reset shadows mean bypass until the next frame start
    gains = {12'h180, 12'h080, 12'h200, 12'h100};
    beat(1'b1, T_PIX, 16'd300, 16'd300);
    idle();
    beat(1'b1, T_PIX, 16'd300, 16'd300);
    idle();
    init_col_phase = 1'b1; init_row_phase = 1'b1;
    frame(2, 4, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/gain_offset.md
# gain_offset

Per-channel black-level subtraction, gain and saturation for a Bayer pixel stream, with round-to-nearest and a per-frame clipped-pixel counter. It sits in the imager datapath at the same point as the white-balance gain stage and uses the same `dvi`/`dtypei`/`datai` stream protocol. Processing has a fixed 3-cycle latency for every beat. Coefficients, mode and Bayer phase are captured once per frame, so register writes never tear a frame.

## Interface
- `GAIN_WIDTH`, 12, total gain coefficient width, unsigned.
- `GAIN_FRAC_WIDTH`, 8, fractional bits of the gain (0x100 = 1.0 at defaults).
- `PIXEL_WIDTH`, 10, pixel width in `datai[PIXEL_WIDTH-1:0]`.
- `DATA_WIDTH`, 16, stream data width.
- `COUNT_WIDTH`, 24, width of the clip counter.
- `clk` in 1: clock.
- `resetb` in 1: reset, asynchronous, active-low.
- `enable` in 1: 1 = process pixels, 0 = bypass; captured at FRAME_START.
- `gains` in 4*GAIN_WIDTH: channel c at `[c*GAIN_WIDTH +: GAIN_WIDTH]`, where c = {row_phase, col_phase}.
- `blacks` in 4*PIXEL_WIDTH: black level per channel, same indexing.
- `init_col_phase`, `init_row_phase` in 1 each: Bayer phase of the first pixel of the frame.
- `dvi` in 1, `dtypei` in `DTYPE_WIDTH`, `datai` in DATA_WIDTH: input stream.
- `dvo` out 1, `dtypeo` out `DTYPE_WIDTH`, `datao` out DATA_WIDTH: output stream.
- `clip_count` out COUNT_WIDTH: number of saturated pixels in the last completed frame.

## Operation
- Shadow registers: on a beat with `dvi`=1 and `DTYPE_FRAME_START`, capture `gains`, `blacks`, `enable` and both init phases. All pixels of the frame use the shadow values. Shadows reset to gains 0, blacks 0, enable 0.
- Phase tracking applies only on `dvi`=1 beats:
  - FRAME_START: col ← init_col, row ← init_row, first_row ← 1.
  - ROW_START: col ← init_col. If first_row=1, then first_row ← 0 and row is unchanged; otherwise row toggles.
  - PIXEL: the pixel uses the current phase, then col toggles.
  - Other dtypes leave the phase unchanged.
- Pixel arithmetic, applied only when `dvi`=1, dtype = PIXEL and shadow enable = 1:
  - s1: d = pix − black[c]. If negative, d = 0. The subtraction is PIXEL_WIDTH+1 bits wide.
  - s2: p = d × gain[c], PIXEL_WIDTH+GAIN_WIDTH bits, full precision.
  - s3: r = p + 2^(GAIN_FRAC_WIDTH−1), one extra bit wide (round half up). When GAIN_FRAC_WIDTH = 0, no rounding term is added.
  - s3: if r ≥ 2^(PIXEL_WIDTH+GAIN_FRAC_WIDTH), the output is all ones (saturation) and the clip event is flagged. Otherwise the output is `r[PIXEL_WIDTH+GAIN_FRAC_WIDTH-1:GAIN_FRAC_WIDTH]`.
  - The result is zero-extended to DATA_WIDTH.
- Pass-through: non-pixel beats, `dvi`=0 beats and bypass mode forward `datai` unchanged, with the same 3-cycle latency.
- Clip counter:
  - The internal counter increments on each saturated pixel and holds at all ones; it does not wrap.
  - On a `DTYPE_FRAME_END` beat leaving s3: `clip_count` ← counter value, including any clip on that same cycle, and the counter ← 0.
  - A FRAME_START at s1 also clears the counter, so frames without FRAME_END do not accumulate. If the FRAME_START clear coincides with a clip increment, the clear wins.

## Timing
- `dvo`, `dtypeo` and `datao` equal `dvi`, `dtypei` and `datai` (or the processed pixel) delayed exactly 3 clocks, every cycle, including bubbles.
- There is no backpressure. A new beat is accepted every cycle.
- Reset values: `dvo`=0, `dtypeo`=0, `datao`=0, `clip_count`=0; all pipeline stages, phases, first_row and the counter are 0.
- Asserting reset mid-frame flushes the pipeline. Output resumes 3 cycles after the first beat following deassertion. Pixels before the next FRAME_START use the reset shadows, which means bypass.
- Changes to `enable`, `gains` or `blacks` mid-frame take effect at the next FRAME_START only.
- The FRAME_START beat itself captures the shadows, and the shadows apply from the next beat onward.

## Test plan
- Identity: enable=1, all gains 0x100, blacks 0; frame of 4×4 pixels with values 0..1023 → `datao` equals input exactly, latency 3, `clip_count`=0.
- Bayer mapping: gains {00:0x100, 01:0x200, 10:0x080, 11:0x180}, init phases 0, all pixels 100.
  - Required output rows: 100, 200, 100, 200… then 50, 150, 50, 150…
  - Repeat with init_col=1: the columns swap.
- Rounding and black level:
  - pix 3, gain 0x080 → 2 (1.5 rounds up).
  - black 64: pix 50 → 0; pix 164 with gain 0x100 → 100.
- Saturation and count:
  - gain 0x200 on pixels 511, 512, 1000 → 1022, 1023, 1023.
  - After FRAME_END, `clip_count`=2.
  - With COUNT_WIDTH=2 and 5 clips → 3.
- Frame-atomic update: change gains and drop enable mid-frame → the current frame is unaffected; the next frame is processed with the new gains, or in bypass with unchanged data.
- Reset mid-frame plus bubbles: `dvi` toggling every other cycle → output `dvi` pattern delayed 3. After reset, outputs are 0 and the next frame's phases start at the init values.
